// File: rtl/io_output_buffer_p_pkg.sv
// Shared definitions for the memory-mapped output buffer: register offsets,
// store size encodings, LCD sequencer states and LCD register bit positions.
package io_out_pkg;

    localparam logic [5:0] OFF_LEDR   = 6'h00;
    localparam logic [5:0] OFF_LEDG   = 6'h10;
    localparam logic [5:0] OFF_HEX_LO = 6'h20;
    localparam logic [5:0] OFF_HEX_HI = 6'h24;
    localparam logic [5:0] OFF_LCD    = 6'h30;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } st_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } lcd_state_e;

    localparam int LCD_RS_BIT   = 8;
    localparam int LCD_RW_BIT   = 9;
    localparam int LCD_EN_BIT   = 10;
    localparam int LCD_BUSY_BIT = 29;
    localparam int LCD_OVF_BIT  = 30;
    localparam int LCD_ON_BIT   = 31;

    // Mask with the low w bits set; used to hide unimplemented LED bits.
    function automatic logic [31:0] width_mask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (w >= 32) ? 32'hFFFF_FFFF : m[31:0];
    endfunction

endpackage

// File: rtl/io_output_buffer_p_if.sv
// LSU-side bus of the output buffer: store/load strobes, address, data and
// the registered load/misalign responses.
interface io_output_buffer_p_if;

    logic        i_buf_en;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic        i_lsu_rden;
    logic [1:0]  i_st_size;
    logic [31:0] o_ld_data;
    logic        o_misalign;

    modport master (
        output i_buf_en, i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_rden, i_st_size,
        input  o_ld_data, o_misalign
    );

    modport slave (
        input  i_buf_en, i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_rden, i_st_size,
        output o_ld_data, o_misalign
    );

endinterface

// File: rtl/io_output_buffer_p_lcd_strobe_seq.sv
// LCD strobe sequencer: latches the LCD fields on a write accepted while idle,
// then walks SETUP -> PULSE (EN high) -> HOLD. Writes arriving while busy are
// dropped and flagged through the sticky overflow bit.
module lcd_strobe_seq
    import io_out_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic       wr_data,
    input  logic       wr_ctl,
    input  logic       wr_on,
    input  logic [9:0] wdata,
    input  logic       won,
    output logic [7:0] data,
    output logic       rs,
    output logic       rw,
    output logic       on,
    output logic       en,
    output logic       busy,
    output logic       ovf
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    lcd_state_e       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    // State, phase counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic: each phase lasts its programmed number of cycles.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (wr) begin
                    state_nxt = SETUP;
                    count_nxt = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (count == '0) begin
                    state_nxt = PULSE;
                    count_nxt = CNT_W'(PULSE_CYC - 1);
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            PULSE: begin
                if (count == '0) begin
                    state_nxt = HOLD;
                    count_nxt = CNT_W'(HOLD_CYC - 1);
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            HOLD: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Field latch on accepted writes; a write while busy only sets overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            rs   <= 1'b0;
            rw   <= 1'b0;
            on   <= 1'b0;
            ovf  <= 1'b0;
        end else if (wr) begin
            if (state == IDLE) begin
                ovf <= 1'b0;
                if (wr_data) data <= wdata[7:0];
                if (wr_ctl) begin
                    rs <= wdata[8];
                    rw <= wdata[9];
                end
                if (wr_on) on <= won;
            end else begin
                ovf <= 1'b1;
            end
        end
    end

    assign en = (state == PULSE);

endmodule

// File: rtl/io_output_buffer_p.sv
// Memory-mapped output peripheral on the LSU path: LEDR/LEDG/HEX registers
// with byte-lane stores, registered read-back, and an LCD strobe sequencer.
module io_output_buffer_p
    import io_out_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
    parameter int NUM_HEX   = 8,
    parameter int LEDR_W    = 32,
    parameter int LEDG_W    = 32,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    io_output_buffer_p_if.slave  bus,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    output logic                 o_lcd_busy
);

    localparam logic [31:0] LEDR_MASK = width_mask(LEDR_W);
    localparam logic [31:0] LEDG_MASK = width_mask(LEDG_W);

    // Byte lanes enabled by a store of the given size at the given low address
    // bits; misaligned or reserved sizes enable nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] low);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_B:    m = 4'b0001 << low;
            SZ_H:    if (!low[0]) m = low[1] ? 4'b1100 : 4'b0011;
            SZ_W:    if (low == 2'b00) m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [5:0]  off, word_off;
    logic        hit, store, misaligned, lcd_wr;
    logic [3:0]  lanes;
    logic [31:0] byte_mask, rd_word, ledr, ledg, hex_lo_word, hex_hi_word, lcd_rd;
    logic [6:0]  hex_all [8];
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_on, lcd_en, lcd_busy, lcd_ovf;

    assign off        = bus.i_lsu_addr[5:0];
    assign word_off   = {off[5:2], 2'b00};
    assign hit        = (bus.i_lsu_addr[31:6] == BASE_ADDR[31:6]);
    assign store      = bus.i_buf_en && bus.i_lsu_wren && hit;
    assign misaligned = ((bus.i_st_size == SZ_H) && off[0]) ||
                        ((bus.i_st_size == SZ_W) && (off[1:0] != 2'b00));
    assign lanes      = store ? lane_mask(bus.i_st_size, off[1:0]) : 4'b0000;
    assign byte_mask  = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    assign lcd_wr     = (word_off == OFF_LCD) && (lanes != 4'b0000);

    // LED registers: only enabled lanes of implemented bits change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr <= '0;
            ledg <= '0;
        end else begin
            if (word_off == OFF_LEDR) ledr <= ((ledr & ~byte_mask) | (bus.i_st_data & byte_mask)) & LEDR_MASK;
            if (word_off == OFF_LEDG) ledg <= ((ledg & ~byte_mask) | (bus.i_st_data & byte_mask)) & LEDG_MASK;
        end
    end

    // One 7-bit register per existing digit; absent digits read as zero.
    for (genvar g = 0; g < 8; g++) begin : g_digit
        if (g < NUM_HEX) begin : g_real
            localparam logic [5:0] HEX_OFF = (g < 4) ? OFF_HEX_LO : OFF_HEX_HI;
            logic [6:0] digit;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) digit <= '0;
                else if ((word_off == HEX_OFF) && lanes[g % 4]) digit <= bus.i_st_data[8*(g%4) +: 7];
            end
            assign hex_all[g] = digit;
            assign o_io_hex[7*g +: 7] = digit;
        end else begin : g_absent
            assign hex_all[g] = '0;
        end
    end

    lcd_strobe_seq #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_lcd_seq (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr      (lcd_wr),
        .wr_data (lanes[0]),
        .wr_ctl  (lanes[1]),
        .wr_on   (lanes[3]),
        .wdata   (bus.i_st_data[9:0]),
        .won     (bus.i_st_data[31]),
        .data    (lcd_data),
        .rs      (lcd_rs),
        .rw      (lcd_rw),
        .on      (lcd_on),
        .en      (lcd_en),
        .busy    (lcd_busy),
        .ovf     (lcd_ovf)
    );

    assign hex_lo_word = {1'b0, hex_all[3], 1'b0, hex_all[2], 1'b0, hex_all[1], 1'b0, hex_all[0]};
    assign hex_hi_word = {1'b0, hex_all[7], 1'b0, hex_all[6], 1'b0, hex_all[5], 1'b0, hex_all[4]};
    assign lcd_rd      = {lcd_on, lcd_ovf, lcd_busy, 18'b0, lcd_en, lcd_rw, lcd_rs, lcd_data};

    // Read-back mux over the aligned word addressed by the load.
    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (word_off)
                OFF_LEDR:   rd_word = ledr;
                OFF_LEDG:   rd_word = ledg;
                OFF_HEX_LO: rd_word = hex_lo_word;
                OFF_HEX_HI: rd_word = hex_hi_word;
                OFF_LCD:    rd_word = lcd_rd;
                default:    rd_word = '0;
            endcase
        end
    end

    // Registered load data (held between loads) and one-cycle misalign pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_ld_data  <= '0;
            bus.o_misalign <= 1'b0;
        end else begin
            if (bus.i_lsu_rden) bus.o_ld_data <= rd_word;
            bus.o_misalign <= store && misaligned;
        end
    end

    assign o_io_ledr  = ledr;
    assign o_io_ledg  = ledg;
    assign o_io_lcd   = {lcd_on, 20'b0, lcd_en, lcd_rw, lcd_rs, lcd_data};
    assign o_lcd_busy = lcd_busy;

endmodule

// File: tb/tb_io_output_buffer_p.sv
// Self-checking bench for io_output_buffer_p: a table of store/load vectors
// with a load-result scoreboard, plus hand-written LCD and reset sequences.
module tb_io_output_buffer_p;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ledr8, ledg8, lcd8, ledr6, ledg6, lcd6;
    logic [55:0] hex8;
    logic [41:0] hex6;
    logic        busy8, busy6;

    int tests_run = 0;
    int tests_failed = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    io_output_buffer_p_if bus8 ();
    io_output_buffer_p_if bus6 ();

    io_output_buffer_p #(.NUM_HEX(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus8.slave),
        .o_io_ledr  (ledr8),
        .o_io_ledg  (ledg8),
        .o_io_hex   (hex8),
        .o_io_lcd   (lcd8),
        .o_lcd_busy (busy8)
    );

    io_output_buffer_p #(.NUM_HEX(6)) dut6 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus6.slave),
        .o_io_ledr  (ledr6),
        .o_io_ledg  (ledg6),
        .o_io_hex   (hex6),
        .o_io_lcd   (lcd6),
        .o_lcd_busy (busy6)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic wr, logic rd, logic [1:0] size,
                                logic [31:0] addr, logic [31:0] data, logic [31:0] exp_ld, logic exp_mis);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.size = size;
        v.addr = addr; v.data = data; v.exp_ld = exp_ld; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle on the selected DUT (0: 8 digits, 1: 6 digits); returns #1 after the edge.
    task automatic apply_stimulus(input int sel, input logic wr, input logic rd, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [31:0] data, input logic en);
        @(negedge clk);
        if (sel == 0) begin
            bus8.i_buf_en = en; bus8.i_lsu_wren = wr; bus8.i_lsu_rden = rd;
            bus8.i_st_size = size; bus8.i_lsu_addr = addr; bus8.i_st_data = data;
        end else begin
            bus6.i_buf_en = en; bus6.i_lsu_wren = wr; bus6.i_lsu_rden = rd;
            bus6.i_st_size = size; bus6.i_lsu_addr = addr; bus6.i_st_data = data;
        end
        @(posedge clk);
        #1;
        bus8.i_lsu_wren = 1'b0; bus8.i_lsu_rden = 1'b0;
        bus6.i_lsu_wren = 1'b0; bus6.i_lsu_rden = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic retire();
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output(e.name, {32'b0, bus8.o_ld_data}, {32'b0, e.exp});
        end
    endtask

    task automatic do_load(input string name, input logic [31:0] addr, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp = exp;
        sb.push_back(e);
        apply_stimulus(0, 1'b0, 1'b1, 2'b10, addr, 32'h0, 1'b1);
        retire();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] exp_hex [8];
        int first_en, en_cnt, busy_cnt;
        logic busy_rise;

        bus8.i_buf_en = 0; bus8.i_lsu_wren = 0; bus8.i_lsu_rden = 0;
        bus8.i_st_size = 0; bus8.i_lsu_addr = 0; bus8.i_st_data = 0;
        bus6.i_buf_en = 0; bus6.i_lsu_wren = 0; bus6.i_lsu_rden = 0;
        bus6.i_st_size = 0; bus6.i_lsu_addr = 0; bus6.i_st_data = 0;

        // Reset state
        #12;
        check_output("rst_ledr", {32'b0, ledr8}, 64'h0);
        check_output("rst_lcd", {32'b0, lcd8}, 64'h0);
        check_output("rst_busy", {63'b0, busy8}, 64'h0);
        check_output("rst_ld", {32'b0, bus8.o_ld_data}, 64'h0);
        check_output("rst_mis", {63'b0, bus8.o_misalign}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: SZ_B=0, SZ_H=1, SZ_W=2, 3 reserved
        vecs.push_back(mk("hexlo_w",     1, 0, 2'd2, 32'h7020, 32'h4F5B063F, 32'h0, 0));
        vecs.push_back(mk("hexhi_w",     1, 0, 2'd2, 32'h7024, 32'h4F5B063F, 32'h0, 0));
        vecs.push_back(mk("hexlo_rd",    0, 1, 2'd2, 32'h7020, 32'h0, 32'h4F5B063F, 0));
        vecs.push_back(mk("hexhi_rd",    0, 1, 2'd2, 32'h7024, 32'h0, 32'h4F5B063F, 0));
        vecs.push_back(mk("ledr_b",      1, 0, 2'd0, 32'h7002, 32'h00A50000, 32'h0, 0));
        vecs.push_back(mk("ledg_h",      1, 0, 2'd1, 32'h7010, 32'h00001234, 32'h0, 0));
        vecs.push_back(mk("ledr_rd",     0, 1, 2'd2, 32'h7000, 32'h0, 32'h00A50000, 0));
        vecs.push_back(mk("ledg_rd_sub", 0, 1, 2'd2, 32'h7012, 32'h0, 32'h00001234, 0));
        vecs.push_back(mk("mis_half",    1, 0, 2'd1, 32'h7001, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk("ledr_rd2",    0, 1, 2'd2, 32'h7003, 32'h0, 32'h00A50000, 0));
        vecs.push_back(mk("mis_word",    1, 0, 2'd2, 32'h7002, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk("rsv_size",    1, 0, 2'd3, 32'h7000, 32'hFFFFFFFF, 32'h0, 0));
        vecs.push_back(mk("ledr_rd3",    0, 1, 2'd2, 32'h7000, 32'h0, 32'h00A50000, 0));
        vecs.push_back(mk("hex3_b",      1, 0, 2'd0, 32'h7023, 32'hFF000000, 32'h0, 0));
        vecs.push_back(mk("hexlo_rd2",   0, 1, 2'd2, 32'h7020, 32'h0, 32'h7F5B063F, 0));
        vecs.push_back(mk("unmapped_w",  1, 0, 2'd2, 32'h7014, 32'hFFFFFFFF, 32'h0, 0));
        vecs.push_back(mk("unmapped_rd", 0, 1, 2'd2, 32'h7014, 32'h0, 32'h0, 0));
        vecs.push_back(mk("ld_st_same",  1, 1, 2'd2, 32'h7010, 32'hCAFEBABE, 32'h00001234, 0));
        vecs.push_back(mk("ledg_rd2",    0, 1, 2'd2, 32'h7010, 32'h0, 32'hCAFEBABE, 0));
        vecs.push_back(mk("ledg_h_hi",   1, 0, 2'd1, 32'h7012, 32'h55550000, 32'h0, 0));
        vecs.push_back(mk("ledg_rd3",    0, 1, 2'd2, 32'h7010, 32'h0, 32'h5555BABE, 0));
        vecs.push_back(mk("ledr_b0",     1, 0, 2'd0, 32'h7000, 32'h000000EE, 32'h0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rd) begin
                sb_t e;
                e.name = vecs[i].name;
                e.exp = vecs[i].exp_ld;
                sb.push_back(e);
            end
            apply_stimulus(0, vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].addr, vecs[i].data, 1'b1);
            check_output({vecs[i].name, "_mis"}, {63'b0, bus8.o_misalign}, {63'b0, vecs[i].exp_mis});
            retire();
        end

        check_output("ld_hold", {32'b0, bus8.o_ld_data}, {32'b0, 32'h5555BABE});
        do_load("ledr_rd4", 32'h7000, 32'h00A500EE);
        check_output("ledr_out", {32'b0, ledr8}, {32'b0, 32'h00A500EE});
        check_output("ledg_out", {32'b0, ledg8}, {32'b0, 32'h5555BABE});
        exp_hex = '{7'h3F, 7'h06, 7'h5B, 7'h7F, 7'h3F, 7'h06, 7'h5B, 7'h4F};
        for (int k = 0; k < 8; k++)
            check_output($sformatf("hex%0d_out", k), {57'b0, hex8[7*k +: 7]}, {57'b0, exp_hex[k]});

        // Six-digit instance: digits 6 and 7 do not exist
        apply_stimulus(1, 1'b1, 1'b0, 2'd2, 32'h7024, 32'hFFFFFFFF, 1'b1);
        apply_stimulus(1, 1'b0, 1'b1, 2'd2, 32'h7024, 32'h0, 1'b1);
        check_output("hex6_rd", {32'b0, bus6.o_ld_data}, {32'b0, 32'h00007F7F});
        check_output("hex6_d4", {57'b0, hex6[28 +: 7]}, 64'h7F);
        check_output("hex6_d5", {57'b0, hex6[35 +: 7]}, 64'h7F);

        // LCD sequence timing
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7030, 32'h80000141, 1'b1);
        first_en = -1; en_cnt = 0; busy_cnt = 0; busy_rise = busy8;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy8) busy_cnt++;
            if (lcd8[10]) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
            end
        end
        check_output("lcd_busy_rise", {63'b0, busy_rise}, 64'h1);
        check_output("lcd_en_cycles", 64'(en_cnt), 64'd4);
        check_output("lcd_en_start", 64'(first_en), 64'd2);
        check_output("lcd_busy_cycles", 64'(busy_cnt), 64'd8);
        check_output("lcd_out_fields", {32'b0, lcd8}, {32'b0, 32'h80000141});
        do_load("lcd_rd", 32'h7030, 32'h80000141);

        // LCD write while busy is dropped and sets overflow
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7030, 32'h80000141, 1'b1);
        idle_cycles(2);
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7030, 32'h000002FF, 1'b1);
        check_output("lcd_busy_drop", {54'b0, lcd8[9:0]}, 64'h141);
        idle_cycles(5);
        do_load("lcd_ovf_rd", 32'h7030, 32'hC0000141);
        apply_stimulus(0, 1'b1, 1'b0, 2'd0, 32'h7030, 32'h00000022, 1'b1);
        do_load("lcd_ovf_clr", 32'h7030, 32'hA0000122);
        idle_cycles(6);
        apply_stimulus(0, 1'b1, 1'b0, 2'd0, 32'h7030, 32'h00000055, 1'b1);
        check_output("lcd_hold_norestart", {63'b0, busy8}, 64'h0);
        do_load("lcd_hold_drop", 32'h7030, 32'hC0000122);

        // Reset in the middle of PULSE
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7030, 32'h80000141, 1'b1);
        idle_cycles(2);
        check_output("pre_rst_en", {63'b0, lcd8[10]}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_lcd", {32'b0, lcd8}, 64'h0);
        check_output("mid_rst_busy", {63'b0, busy8}, 64'h0);
        check_output("mid_rst_ledr", {32'b0, ledr8}, 64'h0);
        check_output("mid_rst_ledg", {32'b0, ledg8}, 64'h0);
        check_output("mid_rst_hex", {8'b0, hex8}, 64'h0);
        check_output("mid_rst_ld", {32'b0, bus8.o_ld_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7000, 32'hFFFFFFFF, 1'b0);
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7020, 32'hFFFFFFFF, 1'b0);
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7030, 32'h80000141, 1'b0);
        check_output("dis_ledr", {32'b0, ledr8}, 64'h0);
        check_output("dis_hex", {8'b0, hex8}, 64'h0);
        check_output("dis_lcd", {31'b0, busy8, lcd8}, 64'h0);
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7040, 32'hFFFFFFFF, 1'b1);
        check_output("oow_ledr", {32'b0, ledr8}, 64'h0);
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 32'h7010, 32'h00000011, 1'b1);
        do_load("ledg_rd_post", 32'h7010, 32'h00000011);
        do_load("oow_rd", 32'h7040, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_output_buffer_p.md
Name: io_output_buffer_p

Overview:
- Parametrised successor to the LSU output buffer. Memory-mapped output peripheral on the LSU store/load path.
- Holds the LEDR, LEDG and HEX digit registers, with a configurable digit count (1..8).
- Supports byte, half and word stores with byte lanes and registered read-back.
- Adds a timed LCD strobe sequencer with busy and overflow status. The old buffer had none of this.

Parameters:
- BASE_ADDR, 32'h0000_7000, base of the 64-byte I/O window; must be 64-byte aligned.
- NUM_HEX, 8, number of 7-segment digits, 1..8.
- LEDR_W, 32, implemented LEDR bits; upper bits read 0.
- LEDG_W, 32, implemented LEDG bits; upper bits read 0.
- SETUP_CYC, 2, cycles from LCD bus valid to EN high (>=1).
- PULSE_CYC, 4, EN-high cycles (>=1).
- HOLD_CYC, 2, cycles bus held after EN low (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_buf_en  in  1  peripheral enable; stores are ignored when 0.
- i_lsu_addr  in  32  byte address.
- i_st_data  in  32  store data, LSB-aligned to the word (lane n = bits [8n+7:8n]).
- i_lsu_wren  in  1  store strobe.
- i_lsu_rden  in  1  load strobe.
- i_st_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as no store).
- o_ld_data  out  32  registered load data.
- o_misalign  out  1  one-cycle pulse on a dropped misaligned in-window store.
- o_io_ledr  out  32  red LEDs.
- o_io_ledg  out  32  green LEDs.
- o_io_hex  out  7*NUM_HEX  digit k at bits [7k+6:7k].
- o_io_lcd  out  32  [7:0] data, [8] RS, [9] RW, [10] EN, [31] ON, others 0.
- o_lcd_busy  out  1  sequencer not idle.

Behaviour:
- Reset (async, i_rst_n=0):
  - All registers 0 and o_ld_data 0.
  - o_misalign 0, o_lcd_busy 0, and FSM goes to IDLE.
  - EN drops immediately, even mid-sequence.
- Decode:
  - The window is hit when i_lsu_addr[31:6] == BASE_ADDR[31:6]; off = i_lsu_addr[5:0].
  - off 0x00 LEDR; 0x10 LEDG; 0x20 HEX0-3 (digit n = lane n); 0x24 HEX4-7; 0x30 LCD.
  - Any other offset: writes ignored, reads 0.
- Stores:
  - A store takes effect on the rising edge when i_buf_en and i_lsu_wren are high and the address hits the window.
  - Byte: lane off[1:0]. Half: lanes off[1]*2+{0,1}, requires off[0]=0. Word: all lanes, requires off[1:0]=0.
  - A misaligned store writes nothing and pulses o_misalign for 1 cycle.
  - Only enabled lanes update.
  - HEX: a lane stores bits [6:0]; lane bit 7 is not stored.
  - Digits k >= NUM_HEX do not exist: their lane writes are discarded and reads return 0.
- Loads:
  - o_ld_data updates one cycle after i_lsu_rden.
  - It returns the full aligned word at off & 6'h3C. Out-of-window or unmapped offsets return 0.
  - It holds its value while i_lsu_rden=0.
  - On a same-cycle load and store, the load returns the pre-store value.
- LCD register write (aligned word or byte lanes):
  - Fields: data[7:0], RS=bit 8, RW=bit 9, ON=bit 31. Bit 10 is not writable.
  - Read-back: [10:0] as driven on o_io_lcd, [29] 0, [30] OVF sticky, [31] ON, and bit 29 replaced by busy... Read-back is fixed as: [30] OVF, [29] BUSY, [31] ON.
- Sequencer FSM, with one down-counter sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC):
  - IDLE: an accepted LCD write latches the fields, clears OVF and moves to SETUP with count SETUP_CYC-1.
  - SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1 for PULSE_CYC cycles, then HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles, then IDLE.
  - The sequence lasts SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
  - o_lcd_busy = (state != IDLE), registered.
- LCD write while busy (including the final HOLD cycle):
  - The write is dropped, the LCD fields are unchanged and OVF is set.
  - An ON-only update is also dropped while busy.
- LED/HEX stores are independent of LCD state.

Decomposition:
- Package io_out_pkg holds:
  - offset constants OFF_LEDR, OFF_LEDG, OFF_HEX_LO, OFF_HEX_HI, OFF_LCD;
  - typedef st_size_e (SZ_B, SZ_H, SZ_W);
  - typedef lcd_state_e (IDLE, SETUP, PULSE, HOLD);
  - LCD bit-position constants.
- One sub-module, lcd_strobe_seq, contains the FSM, counter, busy and OVF logic.
- Byte-lane mask generation stays in the top as a function.

Test Plan:
1. Reset, then word store 32'h4F5B063F to 0x7020 and 0x7024 (NUM_HEX=8) -> hex0=7'h3F, hex1=7'h06, hex2=7'h5B, hex3=7'h4F, and hex4-7 the same; a load of 0x7020 next cycle returns 32'h4F5B063F.
2. LEDR=0; byte store 8'hA5 at 0x7002 and half store 16'h1234 at 0x7010 -> LEDR=32'h00A5_0000, LEDG=32'h0000_1234. Half store at 0x7001 -> no change and o_misalign high for exactly 1 cycle.
3. NUM_HEX=6; word store 32'hFFFF_FFFF to 0x7024 -> hex4=hex5=7'h7F; a load of 0x7024 returns 32'h0000_7F7F.
4. LCD word store 32'h8000_0141 (defaults 2/4/2) -> busy rises next edge; EN high for exactly 4 cycles starting 2 cycles after latch; busy low after 8 cycles; o_io_lcd[7:0]=8'h41, RS=1, ON=1.
5. Second LCD store 3 cycles into a sequence -> fields unchanged and OVF reads 1. The next accepted write clears OVF.
6. Assert i_rst_n=0 during PULSE -> EN and all outputs 0 immediately; after release, a store with i_buf_en=0 leaves every register at 0; an out-of-window store (0x7040) is ignored and its load returns 0.
